gerenciador_projeteis: RTL

Pool of up to N_BALAS independent vertical projectiles for the VGA shooter game (640x480 playfield). Accepts fire requests from the shooter, allocates a free slot, advances every active projectile on a shared movement tick, and retires projectiles that leave the screen or are reported as hits. The block sits between shooter/input logic and the renderer and collision checker, and replaces the single-projectile block.

---
 rtl/jogo_pkg.sv | 15 +
 rtl/projetil_slot.sv | 71 +++++++
 rtl/gerenciador_projeteis.sv | 137 +++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the VGA shooter: playfield size, coordinate type
// and vertical direction encoding used by every game block.
package jogo_pkg;

  localparam int LARGURA_TELA = 640;
  localparam int ALTURA_TELA  = 480;
  localparam int LARG_COORD   = 10;

  // Vertical direction of a projectile: SOBE moves toward y = 0.
  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;

  typedef logic [LARG_COORD-1:0] coord_t;

endpackage

// File: rtl/projetil_slot.sv
// One projectile slot: holds ativo/x/y/dir, loads a new shot on carregar,
// moves PASSO pixels per mover pulse and retires itself at the screen edge.
// Ports:
//   CLOCK_50, reset  clock and asynchronous active-high reset
//   limpar           clears ativo (highest priority)
//   carregar         loads x_in/y_in/dir_in and sets ativo
//   x_in, y_in       spawn position
//   dir_in           spawn direction (SOBE/DESCE)
//   mover            movement tick
//   ativo, x, y      registered slot state
module projetil_slot
  import jogo_pkg::*;
#(
  parameter int PASSO       = 1,
  parameter int ALTURA_TELA = 480
) (
  input  logic   CLOCK_50,
  input  logic   reset,
  input  logic   limpar,
  input  logic   carregar,
  input  coord_t x_in,
  input  coord_t y_in,
  input  logic   dir_in,
  input  logic   mover,
  output logic   ativo,
  output coord_t x,
  output coord_t y
);

  localparam logic [10:0] PASSO_11  = 11'(PASSO);
  localparam logic [10:0] ALTURA_11 = 11'(ALTURA_TELA);
  localparam coord_t      PASSO_C   = coord_t'(PASSO);

  logic   ativo_reg;
  logic   dir_reg;
  coord_t x_reg;
  coord_t y_reg;
  logic [10:0] y_ext;

  // Bounds are checked on 11 bits so y + PASSO cannot wrap.
  assign y_ext = {1'b0, y_reg};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ativo_reg <= 1'b0;
      dir_reg   <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else if (limpar) begin
      ativo_reg <= 1'b0;
    end else if (carregar) begin
      ativo_reg <= 1'b1;
      dir_reg   <= dir_in;
      x_reg     <= x_in;
      y_reg     <= y_in;
    end else if (mover && ativo_reg) begin
      if (dir_reg == SOBE) begin
        if (y_ext < PASSO_11) ativo_reg <= 1'b0;
        else                  y_reg     <= y_reg - PASSO_C;
      end else begin
        if (y_ext + PASSO_11 >= ALTURA_11) ativo_reg <= 1'b0;
        else                               y_reg     <= y_reg + PASSO_C;
      end
    end
  end

  assign ativo = ativo_reg;
  assign x     = x_reg;
  assign y     = y_reg;

endmodule

// File: rtl/gerenciador_projeteis.sv
// Pool of N_BALAS vertical projectiles. Allocates the lowest free slot on a
// fire request, advances all active slots on a shared movement tick and
// retires slots on screen exit or reported hit.
// Ports:
//   CLOCK_50, reset      clock and asynchronous active-high reset
//   pausa                freezes tick, cooldown and firing
//   reiniciarJogo        synchronous clear of all slots and cooldown
//   disparo, sentidoY    fire request and direction (1 = up)
//   xi, yi               shooter position
//   colisao              per-slot hit, clears that slot next cycle
//   disparo_aceito       one-cycle pulse, shot allocated
//   disparo_rejeitado    one-cycle pulse, shot refused
//   ativo, x_flat, y_flat  slot state, slot i at bits [10i+9:10i]
//   raio                 constant projectile radius
module gerenciador_projeteis
  import jogo_pkg::*;
#(
  parameter int N_BALAS        = 4,
  parameter int DIV_TICK       = 50000,
  parameter int PASSO          = 1,
  parameter int ALTURA_TELA    = jogo_pkg::ALTURA_TELA,
  parameter int OFFSET_DISPARO = 35,
  parameter int COOLDOWN       = 8,
  parameter int RAIO           = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  pausa,
  input  logic                  reiniciarJogo,
  input  logic                  disparo,
  input  logic                  sentidoY,
  input  logic [9:0]            xi,
  input  logic [9:0]            yi,
  input  logic [N_BALAS-1:0]    colisao,
  output logic                  disparo_aceito,
  output logic                  disparo_rejeitado,
  output logic [N_BALAS-1:0]    ativo,
  output logic [10*N_BALAS-1:0] x_flat,
  output logic [10*N_BALAS-1:0] y_flat,
  output logic [9:0]            raio
);

  localparam int TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int IW = (N_BALAS > 1) ? $clog2(N_BALAS) : 1;

  localparam logic [TW-1:0] TICK_MAX  = TW'(DIV_TICK - 1);
  localparam logic [CW-1:0] COOL_INI  = CW'(COOLDOWN);
  localparam logic [10:0]   OFFSET_11 = 11'(OFFSET_DISPARO);
  localparam logic [10:0]   ALTURA_11 = 11'(ALTURA_TELA);
  localparam coord_t        OFFSET_C  = coord_t'(OFFSET_DISPARO);

  logic [TW-1:0]      tick_cnt_reg;
  logic [CW-1:0]      cool_reg;
  logic               aceito_reg;
  logic               rejeitado_reg;
  logic               tick;
  logic [N_BALAS-1:0] ativo_w;
  logic               livre;
  logic [IW-1:0]      idx_livre;
  logic               fora_tela;
  logic               aceita;
  coord_t             y_spawn;
  logic [10:0]        yi_ext;

  // Movement tick; the divider stalls while paused so the phase is kept.
  assign tick = (tick_cnt_reg == TICK_MAX) && !pausa;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                       tick_cnt_reg <= '0;
    else if (pausa)                  tick_cnt_reg <= tick_cnt_reg;
    else if (tick_cnt_reg == TICK_MAX) tick_cnt_reg <= '0;
    else                             tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // Lowest-index inactive slot. A slot hit this cycle is still active here,
  // so it cannot be reallocated until the following cycle.
  always_comb begin
    livre     = 1'b0;
    idx_livre = '0;
    for (int i = N_BALAS - 1; i >= 0; i--) begin
      if (!ativo_w[i]) begin
        livre     = 1'b1;
        idx_livre = IW'(i);
      end
    end
  end

  assign yi_ext    = {1'b0, yi};
  assign fora_tela = sentidoY ? (yi_ext < OFFSET_11)
                              : (yi_ext + OFFSET_11 >= ALTURA_11);
  assign aceita    = disparo && !reiniciarJogo && !pausa && (cool_reg == '0)
                     && livre && !fora_tela;
  assign y_spawn   = sentidoY ? (yi - OFFSET_C) : (yi + OFFSET_C);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cool_reg      <= '0;
      aceito_reg    <= 1'b0;
      rejeitado_reg <= 1'b0;
    end else begin
      aceito_reg    <= aceita;
      rejeitado_reg <= disparo && !aceita;
      if (reiniciarJogo)              cool_reg <= '0;
      else if (aceita)                cool_reg <= COOL_INI;
      else if (tick && cool_reg != '0) cool_reg <= cool_reg - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BALAS; gi++) begin : g_slot
      projetil_slot #(
        .PASSO       (PASSO),
        .ALTURA_TELA (ALTURA_TELA)
      ) u_slot (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .limpar   (reiniciarJogo || (colisao[gi] && ativo_w[gi])),
        .carregar (aceita && (idx_livre == IW'(gi))),
        .x_in     (xi),
        .y_in     (y_spawn),
        .dir_in   (sentidoY),
        .mover    (tick),
        .ativo    (ativo_w[gi]),
        .x        (x_flat[10*gi +: 10]),
        .y        (y_flat[10*gi +: 10])
      );
    end
  endgenerate

  assign ativo             = ativo_w;
  assign disparo_aceito    = aceito_reg;
  assign disparo_rejeitado = rejeitado_reg;
  assign raio              = 10'(RAIO);

endmodule
